// File: rtl/mult4_seq.sv
// Sequential 4x4 unsigned multiplier: one shift-add step per RUN cycle through
// a single 4-bit adder, product loaded on the RUN->DONE transition.
module mult4_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q;
    logic [1:0] cnt_q;
    logic [3:0] acc_q;
    logic [3:0] mcand_q;
    logic [3:0] mplr_q;
    logic [7:0] product_q;
    logic       busy_q;
    logic       done_q;

    logic [4:0] step_sum;
    logic [3:0] acc_d;
    logic [3:0] mplr_d;

    // One shift-add step: add on mplr[0], then shift {c,s,mplr} right by one.
    always_comb begin
        step_sum = {1'b0, acc_q};
        if (mplr_q[0]) begin
            step_sum = {1'b0, acc_q} + {1'b0, mcand_q};
        end
        acc_d  = step_sum[4:1];
        mplr_d = {step_sum[0], mplr_q[3:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            acc_q     <= 4'd0;
            mcand_q   <= 4'd0;
            mplr_q    <= 4'd0;
            product_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q <= a;
                        mplr_q  <= b;
                        acc_q   <= 4'd0;
                        cnt_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q  <= acc_d;
                    mplr_q <= mplr_d;
                    cnt_q  <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        product_q <= {acc_d, mplr_d};
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign product   = product_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mult4_seq.sv
// Self-checking bench for mult4_seq: directed scenarios plus an exhaustive
// randomized sweep against an a*b reference with fixed 5-cycle latency.
module tb_mult4_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic [1:0] dbg_state;

    int checks = 0;
    int passes = 0;
    logic [7:0] exp_q[$];
    logic [7:0] prev_prod;

    mult4_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: accept edge, 4 busy cycles with product held, then done with a*b.
    task automatic do_op(input logic [3:0] av, input logic [3:0] bv, input bit scramble);
        logic [7:0] exp;
        start = 1'b1;
        a = av;
        b = bv;
        exp_q.push_back(8'(av) * 8'(bv));
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || product !== prev_prod)
                $display("FAIL run_cycle%0d a=%0d b=%0d: busy=%b done=%b product=%0d, required busy=1 done=0 product=%0d",
                         i, av, bv, busy, done, product, prev_prod);
            else
                passes++;
            if (scramble) begin
                a = 4'($urandom);
                b = 4'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            tick();
        end
        start = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || product !== exp)
            $display("FAIL done_cycle a=%0d b=%0d: busy=%b done=%b product=%0d, required busy=0 done=1 product=%0d",
                     av, bv, busy, done, product, exp);
        else
            passes++;
        prev_prod = exp;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== prev_prod)
            $display("FAIL idle_after a=%0d b=%0d: busy=%b done=%b product=%0d, required busy=0 done=0 product=%0d",
                     av, bv, busy, done, product, prev_prod);
        else
            passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        a = 4'd9;
        b = 4'd9;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00)
            $display("FAIL reset_state: busy=%b done=%b product=%0d, required 0 0 0", busy, done, product);
        else
            passes++;
        start = 1'b0;
        rst = 1'b0;
        prev_prod = 8'h00;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00)
            $display("FAIL idle_no_start: busy=%b done=%b product=%0d, required 0 0 0", busy, done, product);
        else
            passes++;
    endtask

    task automatic test_basic();
        do_op(4'd5, 4'd3, 1'b0);
        do_op(4'd15, 4'd15, 1'b0);
        do_op(4'd7, 4'd0, 1'b0);
        do_op(4'd0, 4'd0, 1'b0);
    endtask

    task automatic test_ignore_start();
        int n_done = 0;
        start = 1'b1;
        a = 4'd2;
        b = 4'd3;
        tick();
        start = 1'b0;
        for (int t = 0; t < 12; t++) begin
            if (t == 1) begin
                start = 1'b1;
                a = 4'd9;
                b = 4'd9;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                n_done++;
                checks++;
                if (product !== 8'd6)
                    $display("FAIL ignore_start_product: product=%0d, required 6", product);
                else
                    passes++;
            end
            tick();
        end
        checks++;
        if (n_done != 1)
            $display("FAIL ignore_start_count: done pulses=%0d, required 1", n_done);
        else
            passes++;
        prev_prod = 8'd6;
    endtask

    task automatic test_back_to_back();
        int phase;
        start = 1'b1;
        a = 4'd4;
        b = 4'd4;
        tick();
        for (int t = 1; t <= 18; t++) begin
            phase = (t - 1) % 6;
            checks++;
            if (busy !== (phase < 4) || done !== (phase == 4) || (phase == 4 && product !== 8'd16))
                $display("FAIL back_to_back t=%0d: busy=%b done=%b product=%0d, required busy=%b done=%b product=16",
                         t, busy, done, product, phase < 4, phase == 4);
            else
                passes++;
            if (t == 18) start = 1'b0;
            tick();
        end
        prev_prod = 8'd16;
    endtask

    task automatic test_reset_mid_run();
        int n_done = 0;
        start = 1'b1;
        a = 4'd6;
        b = 4'd7;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00)
            $display("FAIL reset_mid_run: busy=%b done=%b product=%0d, required 0 0 0", busy, done, product);
        else
            passes++;
        for (int t = 0; t < 8; t++) begin
            if (done === 1'b1 || busy === 1'b1) n_done++;
            tick();
        end
        checks++;
        if (n_done != 0)
            $display("FAIL reset_no_resume: active cycles=%0d, required 0", n_done);
        else
            passes++;
        prev_prod = 8'h00;
        do_op(4'd6, 4'd7, 1'b0);
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 256; i++) begin
            do_op(4'(i >> 4), 4'(i), 1'b1);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = 4'd0;
        b = 4'd0;
        prev_prod = 8'h00;
        test_reset();
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
